// File: rtl/switch_event_pkg.sv
// Shared constants for the switch event controller: bus addresses, control/status
// bit positions, FIFO entry and count widths, and the DEPTH legality check.
package switch_event_pkg;

    localparam logic AddrEvent = 1'b0;
    localparam logic AddrCtrl  = 1'b1;

    localparam int unsigned EntryW = 16;
    localparam int unsigned CountW = 4;

    localparam int unsigned BitEnable    = 8;
    localparam int unsigned BitIntEnable = 9;
    localparam int unsigned BitOverflow  = 10;

    typedef enum logic {StIdle, StAck} hs_state_e;

    // Depth must be a power of two in 2..8 so pointers wrap naturally and count fits CountW.
    function automatic bit depth_ok(input int unsigned d);
        return (d >= 2) && (d <= 8) && ((d & (d - 1)) == 0);
    endfunction

endpackage

// File: rtl/event_fifo.sv
// Single-clock synchronous FIFO holding switch change events.
// A push into a full FIFO succeeds only when a pop happens on the same edge.
module event_fifo
    import switch_event_pkg::*;
#(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = EntryW
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic [Width-1:0]  data_i,
    input  logic              pop_i,
    output logic [Width-1:0]  data_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [CountW-1:0] count_o
);

    localparam int unsigned PtrW = $clog2(Depth);

    logic [Width-1:0]  mem_q [Depth];
    logic [Width-1:0]  mem_d [Depth];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CountW-1:0] count_q, count_d;
    logic              push_ok, pop_ok;

    assign full_o  = (count_q == CountW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + CountW'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - CountW'(1);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/switch_event_ctrl.sv
// Bus-attached switch event controller: detects changes on the debounced switch
// bank, queues them as events, and raises a level interrupt while events or an
// overflow are pending.
module switch_event_ctrl
    import switch_event_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        Address,
    input  logic        Read,
    input  logic        Write,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic        Ready,
    input  logic [7:0]  Switch_in,
    output logic        Interrupt
);

    if (!depth_ok(DEPTH)) begin : g_bad_depth
        $error("switch_event_ctrl: DEPTH must be a power of two in 2..8");
    end

    hs_state_e         state_q, state_d;
    logic [7:0]        prev_q, prev_d;
    logic [31:0]       dout_q, dout_d;
    logic              irq_q, irq_d;
    logic              en_q, en_d;
    logic              ie_q, ie_d;
    logic              ovf_q, ovf_d;

    logic [7:0]        change;
    logic              push, pop;
    logic              txn, txn_wr, txn_rd;
    logic [EntryW-1:0] fifo_data;
    logic              fifo_full, fifo_empty;
    logic [CountW-1:0] fifo_count;
    logic [31:0]       status_word;
    logic              unused_din;

    assign unused_din = ^{DataIn[31:11], DataIn[7:0]};

    assign change = Switch_in ^ prev_q;
    assign push   = (change != '0) & en_q;

    // A transaction takes effect only on the IDLE->ACK edge; Write dominates Read.
    assign txn    = (state_q == StIdle) & (Read | Write);
    assign txn_wr = txn & Write;
    assign txn_rd = txn & Read & ~Write;
    assign pop    = txn_rd & (Address == AddrEvent) & ~fifo_empty;

    assign status_word = {16'b0, fifo_count, 1'b0, ovf_q, ie_q, en_q, Switch_in};

    assign Ready     = (state_q == StAck);
    assign DataOut   = dout_q;
    assign Interrupt = irq_q;

    event_fifo #(
        .Depth (DEPTH),
        .Width (EntryW)
    ) u_fifo (
        .clk_i   (clock),
        .rst_i   (reset),
        .push_i  (push),
        .data_i  ({change, Switch_in}),
        .pop_i   (pop),
        .data_o  (fifo_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Handshake FSM next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (Read || Write) state_d = StAck;
            StAck:  if (!(Read || Write)) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Control register, read data, overflow and interrupt next state.
    always_comb begin
        prev_d = Switch_in;
        en_d   = en_q;
        ie_d   = ie_q;
        ovf_d  = ovf_q;
        dout_d = dout_q;
        if (txn_wr && (Address == AddrCtrl)) begin
            en_d = DataIn[BitEnable];
            ie_d = DataIn[BitIntEnable];
            if (DataIn[BitOverflow]) ovf_d = 1'b0;
        end
        // Applied after the clear so a same-cycle overflow keeps the flag set.
        if (push && fifo_full && !pop) ovf_d = 1'b1;
        if (txn_rd) begin
            if (Address == AddrEvent) begin
                dout_d = fifo_empty ? 32'h0 : {15'b0, 1'b1, fifo_data};
            end else begin
                dout_d = status_word;
            end
        end
        irq_d = ie_q & ((fifo_count != '0) | ovf_q);
    end

    // State registers; Prev tracks the switches even in reset to avoid a release event.
    always_ff @(posedge clock) begin
        prev_q <= prev_d;
        if (reset) begin
            state_q <= StIdle;
            dout_q  <= '0;
            irq_q   <= 1'b0;
            en_q    <= 1'b0;
            ie_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dout_q  <= dout_d;
            irq_q   <= irq_d;
            en_q    <= en_d;
            ie_q    <= ie_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_switch_event_ctrl.sv
// Self-checking bench for switch_event_ctrl with a queue-based reference model.
module tb_switch_event_ctrl;

    localparam int unsigned DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        Address = 1'b0;
    logic        Read = 1'b0;
    logic        Write = 1'b0;
    logic [31:0] DataIn = '0;
    logic [31:0] DataOut;
    logic        Ready;
    logic [7:0]  Switch_in = 8'h00;
    logic        Interrupt;

    int checks = 0;
    int failures = 0;

    switch_event_ctrl #(.DEPTH(DEPTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .Address   (Address),
        .Read      (Read),
        .Write     (Write),
        .DataIn    (DataIn),
        .DataOut   (DataOut),
        .Ready     (Ready),
        .Switch_in (Switch_in),
        .Interrupt (Interrupt)
    );

    always #5 clock = ~clock;

    // Reference model: event queue plus control bits, advanced once per rising edge.
    bit [15:0]   m_q[$];
    bit          m_en, m_ie, m_ovf;
    logic [7:0]  m_prev = 8'h00;
    logic [31:0] exp_dout = '0;
    logic        exp_ready = 1'b0;
    logic        exp_irq = 1'b0;
    logic [7:0]  m_chg;
    int          m_n;
    bit          m_pop, m_new_en, m_new_ie, m_clr;

    initial forever begin
        @(posedge clock);
        if (reset) begin
            m_q.delete();
            m_en = 0; m_ie = 0; m_ovf = 0;
            m_prev = Switch_in;
            exp_ready = 0; exp_dout = '0; exp_irq = 0;
        end else begin
            m_n = m_q.size();
            m_chg = Switch_in ^ m_prev;
            m_prev = Switch_in;
            exp_irq = m_ie && ((m_n != 0) || m_ovf);
            m_pop = 0; m_new_en = m_en; m_new_ie = m_ie; m_clr = 0;
            if (!exp_ready && (Read || Write)) begin
                if (Write) begin
                    if (Address) begin
                        m_new_en = DataIn[8]; m_new_ie = DataIn[9]; m_clr = DataIn[10];
                    end
                end else if (!Address) begin
                    if (m_n > 0) begin
                        exp_dout = {15'd0, 1'b1, m_q[0]};
                        m_pop = 1;
                    end else begin
                        exp_dout = '0;
                    end
                end else begin
                    exp_dout = {16'd0, 4'(m_n), 1'b0, m_ovf, m_ie, m_en, Switch_in};
                end
            end
            exp_ready = Read || Write;
            if (m_clr) m_ovf = 0;
            if (m_pop) void'(m_q.pop_front());
            if ((m_chg != 0) && m_en) begin
                if (m_q.size() < DEPTH) m_q.push_back({m_chg, Switch_in});
                else m_ovf = 1;
            end
            m_en = m_new_en;
            m_ie = m_new_ie;
        end
    end

    // One bus transaction; returns read data and whether a handshake bound expired.
    task automatic bus(input logic r, input logic w, input logic a, input logic [31:0] d,
                       input logic [7:0] s, output logic [31:0] dout, output bit to);
        @(negedge clock);
        Read = r; Write = w; Address = a; DataIn = d; Switch_in = s;
        to = 1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (Ready) begin to = 0; break; end
        end
        dout = DataOut;
        Read = 0; Write = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (!Ready) break;
            if (i == 7) to = 1;
        end
    endtask

    task automatic test_reset();
        logic [31:0] d; bit to;
        reset = 1; Switch_in = 8'h5A;
        repeat (3) @(negedge clock);
        reset = 0;
        repeat (10) @(negedge clock);
        checks++; if (Ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", Ready); end
        checks++; if (DataOut !== 32'h0) begin failures++; $display("FAIL reset_dout got=%h exp=0", DataOut); end
        checks++; if (Interrupt !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", Interrupt); end
        bus(1, 0, 1, 0, Switch_in, d, to);
        checks++; if (to !== 1'b0) begin failures++; $display("FAIL reset_status_to got=%b exp=0", to); end
        checks++; if (d !== 32'h0000005A) begin failures++; $display("FAIL reset_status got=%h exp=0000005a", d); end
    endtask

    task automatic test_irq_basic();
        logic [31:0] d; bit to;
        @(negedge clock); Switch_in = 8'h00;
        bus(0, 1, 1, 32'h300, 8'h00, d, to);
        checks++; if (to !== 1'b0) begin failures++; $display("FAIL irq_wr_to got=%b exp=0", to); end
        Switch_in = 8'h81;
        @(negedge clock);
        checks++; if (Interrupt !== 1'b0) begin failures++; $display("FAIL irq_edge1 got=%b exp=0", Interrupt); end
        @(negedge clock);
        checks++; if (Interrupt !== 1'b1) begin failures++; $display("FAIL irq_edge2 got=%b exp=1", Interrupt); end
        bus(1, 0, 0, 0, Switch_in, d, to);
        checks++; if (d !== 32'h00018181) begin failures++; $display("FAIL irq_read1 got=%h exp=00018181", d); end
        bus(1, 0, 0, 0, Switch_in, d, to);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL irq_read2 got=%h exp=0", d); end
        checks++; if (Interrupt !== 1'b0) begin failures++; $display("FAIL irq_fall got=%b exp=0", Interrupt); end
    endtask

    task automatic test_overflow();
        logic [31:0] d; bit to;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            Switch_in = Switch_in ^ 8'($urandom_range(1, 255));
        end
        bus(1, 0, 1, 0, Switch_in, d, to);
        checks++; if (d[15:8] !== 8'h47) begin failures++; $display("FAIL ovf_status got=%h exp=47", d[15:8]); end
        checks++; if (d !== exp_dout) begin failures++; $display("FAIL ovf_model got=%h exp=%h", d, exp_dout); end
        bus(0, 1, 1, 32'h700, Switch_in, d, to);
        bus(1, 0, 1, 0, Switch_in, d, to);
        checks++; if (d[15:8] !== 8'h43) begin failures++; $display("FAIL ovf_clear got=%h exp=43", d[15:8]); end
    endtask

    task automatic test_push_pop_full();
        logic [31:0] d; bit to;
        for (int i = 0; i < 6; i++) begin
            bus(1, 0, 0, 0, Switch_in ^ 8'($urandom_range(1, 255)), d, to);
            checks++; if (to !== 1'b0) begin failures++; $display("FAIL pp_to i=%0d got=%b exp=0", i, to); end
            checks++; if (d !== exp_dout) begin failures++; $display("FAIL pp_data i=%0d got=%h exp=%h", i, d, exp_dout); end
            checks++; if (d[16] !== 1'b1) begin failures++; $display("FAIL pp_valid i=%0d got=%b exp=1", i, d[16]); end
        end
        bus(1, 0, 1, 0, Switch_in, d, to);
        checks++; if (d[15:8] !== 8'h43) begin failures++; $display("FAIL pp_status got=%h exp=43", d[15:8]); end
        for (int i = 0; i < 4; i++) begin
            bus(1, 0, 0, 0, Switch_in, d, to);
            checks++; if (d !== exp_dout || d[16] !== 1'b1) begin
                failures++; $display("FAIL pp_drain i=%0d got=%h exp=%h", i, d, exp_dout);
            end
        end
        bus(1, 0, 0, 0, Switch_in, d, to);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL pp_empty got=%h exp=0", d); end
        checks++; if (Interrupt !== 1'b0) begin failures++; $display("FAIL pp_irq got=%b exp=0", Interrupt); end
    endtask

    task automatic test_hold_read();
        logic [31:0] d, prev; bit to;
        @(negedge clock); Switch_in = Switch_in ^ 8'h01;
        @(negedge clock); Switch_in = Switch_in ^ 8'h02;
        @(negedge clock); Read = 1; Address = 0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clock);
            checks++; if (Ready !== 1'b1) begin failures++; $display("FAIL hold_ready c=%0d got=%b exp=1", i + 1, Ready); end
        end
        Read = 0;
        @(negedge clock);
        checks++; if (Ready !== 1'b0) begin failures++; $display("FAIL hold_fall got=%b exp=0", Ready); end
        checks++; if (DataOut[16:8] !== 9'h101 || DataOut !== exp_dout) begin
            failures++; $display("FAIL hold_data got=%h exp=%h", DataOut, exp_dout);
        end
        bus(1, 0, 1, 0, Switch_in, d, to);
        checks++; if (d[15:12] !== 4'd1) begin failures++; $display("FAIL hold_count got=%0d exp=1", d[15:12]); end
        prev = exp_dout;
        bus(1, 1, 1, 32'h100, Switch_in, d, to);
        checks++; if (d !== prev) begin failures++; $display("FAIL rw_dout got=%h exp=%h", d, prev); end
        bus(1, 0, 1, 0, Switch_in, d, to);
        checks++; if (d[10:8] !== 3'b001) begin failures++; $display("FAIL rw_ctrl got=%b exp=001", d[10:8]); end
        checks++; if (Interrupt !== 1'b0) begin failures++; $display("FAIL rw_irq got=%b exp=0", Interrupt); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d; bit to;
        bus(0, 1, 1, 32'h300, Switch_in, d, to);
        @(negedge clock); Switch_in = Switch_in ^ 8'h10; Read = 1; Address = 1;
        @(negedge clock);
        checks++; if (Ready !== 1'b1) begin failures++; $display("FAIL rm_ready got=%b exp=1", Ready); end
        reset = 1;
        @(negedge clock);
        checks++; if (Ready !== 1'b0) begin failures++; $display("FAIL rm_reset got=%b exp=0", Ready); end
        reset = 0;
        @(negedge clock);
        checks++; if (Ready !== 1'b1) begin failures++; $display("FAIL rm_new_txn got=%b exp=1", Ready); end
        checks++; if (DataOut !== {24'd0, Switch_in}) begin
            failures++; $display("FAIL rm_status got=%h exp=%h", DataOut, {24'd0, Switch_in});
        end
        checks++; if (Interrupt !== 1'b0) begin failures++; $display("FAIL rm_irq got=%b exp=0", Interrupt); end
        Read = 0;
        @(negedge clock);
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            @(negedge clock);
            checks++; if (Ready !== exp_ready) begin failures++; $display("FAIL rand_ready c=%0d got=%b exp=%b", c, Ready, exp_ready); end
            checks++; if (DataOut !== exp_dout) begin failures++; $display("FAIL rand_dout c=%0d got=%h exp=%h", c, DataOut, exp_dout); end
            checks++; if (Interrupt !== exp_irq) begin failures++; $display("FAIL rand_irq c=%0d got=%b exp=%b", c, Interrupt, exp_irq); end
            reset   = ($urandom_range(0, 49) == 0);
            Read    = $urandom_range(0, 1) == 1;
            Write   = $urandom_range(0, 4) == 0;
            Address = $urandom_range(0, 1) == 1;
            DataIn  = $urandom;
            if ($urandom_range(0, 2) == 0) Switch_in = 8'($urandom);
        end
        reset = 0; Read = 0; Write = 0;
        @(negedge clock);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_irq_basic();
        test_overflow();
        test_push_pop_full();
        test_hold_read();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
